// File: rtl/fifo_read_streamer.sv
// Read-side adapter for the dual-clock FIFO: pops words, absorbs the one-cycle
// read latency in a 2-entry skid buffer and presents a framed valid/ready stream.
module fifo_read_streamer #(
  parameter int DSIZE   = 8,
  parameter int PKT_LEN = 8,
  parameter int CNT_W   = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             en,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [PW-1:0] LAST_IDX = PW'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [1:0]       occ;
  logic             inflight;
  logic [DSIZE-1:0] buf0;
  logic [DSIZE-1:0] buf1;
  logic [PW-1:0]    pkt_idx;
  logic             pop;
  logic [2:0]       slots_used;

  assign m_valid    = (occ != 2'd0);
  assign m_data     = buf0;
  assign m_last     = m_valid && (pkt_idx == LAST_IDX);
  assign pop        = m_valid && m_ready;
  // Slots that will be claimed after this edge, counting the word still in flight.
  assign slots_used = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (en) state_nxt = RUN;
      RUN:     if (!en) state_nxt = FLUSH;
      FLUSH: begin
        if (en) begin
          state_nxt = RUN;
        end else if (occ == 2'd0 && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN) || (state == FLUSH);
    rinc = !rrst && (state == RUN) && !rempty && (slots_used < 3'd2);
  end

  // buf0 is always the head; the word arriving from the FIFO lands behind whatever remains.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ      <= 2'd0;
      inflight <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      inflight <= rinc;
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            buf0 <= rdata;
          end else begin
            buf1 <= rdata;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            buf0 <= buf1;
            buf1 <= rdata;
          end else begin
            buf0 <= rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Packet position survives FLUSH/IDLE so an interrupted packet resumes where it left off.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      pkt_idx  <= '0;
      beat_cnt <= '0;
    end else if (pop) begin
      pkt_idx  <= (pkt_idx == LAST_IDX) ? '0 : pkt_idx + PW'(1);
      beat_cnt <= beat_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_read_streamer.sv
// Scoreboard bench for fifo_read_streamer: a FIFO model feeds the DUT and a
// negedge monitor checks every delivered beat against the loaded word order.
module tb_fifo_read_streamer;

  logic       clk = 1'b0;
  logic       rrst;
  logic       en;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       busy;
  logic [3:0] beat_cnt;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  int         check_count = 0;
  int         pass_count  = 0;
  int         pop_count   = 0;
  int         rinc_count  = 0;
  int         idx_model   = 0;
  int         cnt_model   = 0;
  logic       prev_stall  = 1'b0;
  logic [7:0] prev_data   = 8'h00;
  logic       prev_last   = 1'b0;

  fifo_read_streamer #(.DSIZE(8), .PKT_LEN(8), .CNT_W(4)) dut (
    .rclk     (clk),
    .rrst     (rrst),
    .en       (en),
    .rempty   (rempty),
    .rdata    (rdata),
    .rinc     (rinc),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .busy     (busy),
    .beat_cnt (beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + 8'(i));
      exp_q.push_back(base + 8'(i));
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic waitDrain(input string name, input int max_cycles);
    for (int i = 0; i < max_cycles && (exp_q.size() != 0 || m_valid); i++) tick(1);
    checkOutput(name, 32'(exp_q.size()), 32'd0);
  endtask

  // FIFO model: a word appears on rdata the cycle after rinc; the empty flag follows the queue.
  initial rempty = 1'b1;
  initial rdata  = 8'h00;
  always @(posedge clk) begin
    logic [7:0] w;
    if (rinc === 1'b1) begin
      rinc_count++;
      checkOutput("rinc_nonempty", 32'(fifo_q.size() != 0), 32'd1);
      if (fifo_q.size() != 0) begin
        w = fifo_q.pop_front();
        rdata <= w;
      end
    end
    #1 rempty = (fifo_q.size() == 0);
  end

  // Monitor: every accepted beat is popped from the scoreboard and its framing verified.
  always @(negedge clk) begin
    logic [7:0] e;
    if (rrst) begin
      idx_model  = 0;
      cnt_model  = 0;
      prev_stall = 1'b0;
      checkOutput("rinc_in_reset", 32'(rinc), 32'd0);
    end else begin
      checkOutput("beat_cnt", 32'(beat_cnt), 32'(cnt_model));
      if (rempty) checkOutput("rinc_while_empty", 32'(rinc), 32'd0);
      if (prev_stall) begin
        checkOutput("hold_valid", 32'(m_valid), 32'd1);
        checkOutput("hold_data", 32'(m_data), 32'(prev_data));
        checkOutput("hold_last", 32'(m_last), 32'(prev_last));
      end
      if (!m_valid) checkOutput("last_without_valid", 32'(m_last), 32'd0);
      if (m_valid && m_ready) begin
        checkOutput("beat_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          checkOutput("m_data", 32'(m_data), 32'(e));
        end
        checkOutput("m_last", 32'(m_last), 32'(idx_model == 7));
        idx_model = (idx_model + 1) % 8;
        cnt_model = (cnt_model + 1) % 16;
        pop_count++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    rrst    = 1'b1;
    en      = 1'b1;
    m_ready = 1'b0;

    // Reset with data waiting and en high
    applyStimulus(8'hA0, 8);
    tick(2);
    checkOutput("t1_rinc", 32'(rinc), 32'd0);
    checkOutput("t1_m_valid", 32'(m_valid), 32'd0);
    checkOutput("t1_beat_cnt", 32'(beat_cnt), 32'd0);
    checkOutput("t1_busy", 32'(busy), 32'd0);
    checkOutput("t1_m_last", 32'(m_last), 32'd0);

    // Streaming with two-cycle first-word latency
    rrst    = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 10 && !rinc; i++) tick(1);
    checkOutput("t2_first_rinc", 32'(rinc), 32'd1);
    tick(1);
    checkOutput("t2_valid_n1", 32'(m_valid), 32'd0);
    tick(1);
    checkOutput("t2_valid_n2", 32'(m_valid), 32'd1);
    checkOutput("t2_data_n2", 32'(m_data), 32'h0A0);
    checkOutput("t2_busy", 32'(busy), 32'd1);
    tick(7);
    checkOutput("t2_throughput_pops", 32'(pop_count), 32'd7);
    waitDrain("t2_drain", 20);
    checkOutput("t2_beat_cnt", 32'(beat_cnt), 32'd8);

    // Backpressure: buffer fills to two, fetching stops, data held
    applyStimulus(8'hB0, 8);
    tick(3);
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if (i >= 3) begin
        checkOutput("t3_rinc_full", 32'(rinc), 32'd0);
        checkOutput("t3_valid_full", 32'(m_valid), 32'd1);
      end
    end
    m_ready = 1'b1;
    waitDrain("t3_drain", 30);
    checkOutput("t3_beat_cnt_wrapped", 32'(beat_cnt), 32'd0);

    // Short FIFO: exactly three pops then the stream goes quiet
    rinc_count = 0;
    applyStimulus(8'hC0, 3);
    waitDrain("t4_drain", 30);
    tick(3);
    checkOutput("t4_rinc_pulses", 32'(rinc_count), 32'd3);
    checkOutput("t4_valid_low", 32'(m_valid), 32'd0);
    checkOutput("t4_beat_cnt", 32'(beat_cnt), 32'd3);

    // Flush: stop fetching with two words buffered, then resume the packet
    rrst = 1'b1;
    tick(2);
    rrst = 1'b0;
    base = pop_count;
    applyStimulus(8'hD0, 8);
    for (int i = 0; i < 40 && (pop_count - base) < 3; i++) tick(1);
    m_ready = 1'b0;
    checkOutput("t5_three_pops", 32'(pop_count - base), 32'd3);
    tick(3);
    en = 1'b0;
    tick(2);
    checkOutput("t5_rinc_flush", 32'(rinc), 32'd0);
    checkOutput("t5_busy_flush", 32'(busy), 32'd1);
    checkOutput("t5_valid_flush", 32'(m_valid), 32'd1);
    m_ready = 1'b1;
    tick(4);
    checkOutput("t5_drained_two", 32'(pop_count - base), 32'd5);
    checkOutput("t5_valid_idle", 32'(m_valid), 32'd0);
    checkOutput("t5_busy_idle", 32'(busy), 32'd0);
    checkOutput("t5_rinc_idle", 32'(rinc), 32'd0);
    en = 1'b1;
    waitDrain("t5_drain", 30);
    checkOutput("t5_beat_cnt", 32'(beat_cnt), 32'd8);

    // Counter wrap after 17 beats
    rrst = 1'b1;
    tick(2);
    rrst = 1'b0;
    applyStimulus(8'h10, 17);
    waitDrain("t6_drain", 60);
    checkOutput("t6_beat_cnt_wrap", 32'(beat_cnt), 32'd1);

    // Reset mid-stream: stale and in-flight words must never appear
    base = pop_count;
    applyStimulus(8'h60, 8);
    for (int i = 0; i < 30 && (pop_count - base) < 2; i++) tick(1);
    rrst = 1'b1;
    tick(1);
    checkOutput("t6_valid_after_rst", 32'(m_valid), 32'd0);
    checkOutput("t6_rinc_after_rst", 32'(rinc), 32'd0);
    checkOutput("t6_cnt_after_rst", 32'(beat_cnt), 32'd0);
    exp_q.delete();
    fifo_q.delete();
    tick(1);
    rrst = 1'b0;
    applyStimulus(8'h70, 4);
    waitDrain("t6_post_rst_drain", 30);
    checkOutput("t6_post_rst_cnt", 32'(beat_cnt), 32'd4);

    tick(2);
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
